// File: rtl/vec_ctrl_unit.sv
// rtl/vec_ctrl_unit.sv - registered opcode decode, multi-beat vector sequencing
// and BEQ resolve/flush FSM between fetch and the execute datapath.
module vec_ctrl_unit #(
  parameter int          LANES        = 4,
  parameter int          VLEN_MAX     = 16,
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [5:0]  OP_RTYPE     = 6'h00,
  parameter logic [5:0]  OP_LW        = 6'h23,
  parameter logic [5:0]  OP_SW        = 6'h2B,
  parameter logic [5:0]  OP_LW_R      = 6'h30,
  parameter logic [5:0]  OP_SW_R      = 6'h38,
  parameter logic [5:0]  OP_BEQ       = 6'h04,
  parameter logic [5:0]  OP_ADDI      = 6'h08,
  parameter logic [5:0]  OP_SET       = 6'h0F,
  localparam int         VL_W         = $clog2(VLEN_MAX + 1),
  localparam int         NBEATS       = (VLEN_MAX + LANES - 1) / LANES,
  localparam int         BEAT_W       = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instn_valid,
  input  logic [31:0]       instn,
  input  logic [VL_W-1:0]   vlen,
  output logic              instn_ready,
  input  logic              branch_resolved,
  input  logic              branch_taken,
  output logic              ctrl_valid,
  output logic [5:0]        opcode,
  output logic              RegDst,
  output logic [1:0]        ALUOp,
  output logic              ALUSrc,
  output logic              branch,
  output logic              MemWrite,
  output logic              RegWrite,
  output logic              MemtoReg,
  output logic [BEAT_W-1:0] beat_idx,
  output logic [LANES-1:0]  lane_mask,
  output logic              beq_enable,
  output logic              flush,
  output logic [1:0]        state
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_NORMAL   = 2'b00,
    S_BEQ_WAIT = 2'b01,
    S_FLUSH    = 2'b10,
    S_VEC      = 2'b11
  } state_t;

  state_t st, st_nxt;

  logic [5:0]        op_in;
  logic              accept;
  logic              is_vec;
  logic              multi;
  logic [VL_W-1:0]   vlen_c;
  logic [VL_W-1:0]   elems_q;
  logic [VL_W-1:0]   elems_nxt;
  logic [FC_W-1:0]   fcnt_q;
  logic              valid_q;
  logic [5:0]        op_q;
  logic [7:0]        ctrl_q;
  logic [BEAT_W-1:0] beat_q;
  logic [LANES-1:0]  mask_q;
  logic              unused_bits;

  // Control word packing: {RegDst, ALUOp[1:0], ALUSrc, branch, MemWrite, RegWrite, MemtoReg}
  function automatic logic [7:0] decode(input logic [5:0] op);
    logic [7:0] c;
    c = 8'b0;
    case (op)
      OP_RTYPE:        c = 8'b1_10_0_0_0_1_0;
      OP_LW:           c = 8'b0_10_1_0_0_1_1;
      OP_SW:           c = 8'b0_00_1_0_1_0_0;
      OP_LW_R:         c = 8'b1_10_0_0_0_1_1;
      OP_SW_R:         c = 8'b1_10_0_0_1_0_0;
      OP_BEQ:          c = 8'b0_01_0_1_0_0_0;
      OP_ADDI, OP_SET: c = 8'b0_00_1_0_0_1_0;
      default:         c = 8'b0;
    endcase
    return c;
  endfunction

  function automatic logic [LANES-1:0] mask_of(input logic [VL_W-1:0] e);
    logic [LANES-1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) begin
      m[i] = (32'(e) > $unsigned(i));
    end
    return m;
  endfunction

  assign op_in       = instn[31:26];
  assign unused_bits = ^instn[25:0];
  assign instn_ready = (st == S_NORMAL);
  assign accept      = instn_ready && instn_valid;
  assign vlen_c      = (32'(vlen) > 32'(VLEN_MAX)) ? VL_W'(VLEN_MAX) : vlen;
  assign is_vec      = (op_in == OP_RTYPE) || (op_in == OP_LW_R) || (op_in == OP_SW_R);
  assign multi       = is_vec && (32'(vlen_c) > 32'(LANES));
  assign elems_nxt   = (32'(elems_q) > 32'(LANES)) ? VL_W'(32'(elems_q) - 32'(LANES)) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= S_NORMAL;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      S_NORMAL: begin
        if (accept) begin
          if (op_in == OP_BEQ) st_nxt = S_BEQ_WAIT;
          else if (multi)      st_nxt = S_VEC;
          else                 st_nxt = S_NORMAL;
        end
      end
      // elems_nxt is the element count of the beat being issued at this edge
      S_VEC: begin
        if (32'(elems_nxt) <= 32'(LANES)) st_nxt = S_NORMAL;
      end
      S_BEQ_WAIT: begin
        if (branch_resolved) begin
          if (branch_taken && (FLUSH_CYCLES > 0)) st_nxt = S_FLUSH;
          else                                    st_nxt = S_NORMAL;
        end
      end
      S_FLUSH: begin
        if (fcnt_q == '0) st_nxt = S_NORMAL;
      end
      default: st_nxt = S_NORMAL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      op_q    <= '0;
      ctrl_q  <= '0;
      beat_q  <= '0;
      mask_q  <= '0;
      elems_q <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      op_q    <= op_in;
      ctrl_q  <= decode(op_in);
      beat_q  <= '0;
      if (is_vec) begin
        elems_q <= vlen_c;
        mask_q  <= mask_of(vlen_c);
      end else begin
        elems_q <= '0;
        mask_q  <= LANES'(1);
      end
    end else if (st == S_VEC) begin
      valid_q <= 1'b1;
      beat_q  <= beat_q + BEAT_W'(1);
      elems_q <= elems_nxt;
      mask_q  <= mask_of(elems_nxt);
    end else begin
      valid_q <= 1'b0;
    end
  end

  // Loaded on every non-FLUSH cycle so it is primed on the edge entering FLUSH
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                fcnt_q <= '0;
    else if (st != S_FLUSH) fcnt_q <= FC_W'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);
    else if (fcnt_q != '0)  fcnt_q <= fcnt_q - FC_W'(1);
  end

  assign ctrl_valid = valid_q;
  assign opcode     = valid_q ? op_q : '0;
  assign {RegDst, ALUOp, ALUSrc, branch, MemWrite, RegWrite, MemtoReg} = valid_q ? ctrl_q : 8'b0;
  assign beat_idx   = valid_q ? beat_q : '0;
  assign lane_mask  = valid_q ? mask_q : '0;
  assign beq_enable = (st == S_BEQ_WAIT);
  assign flush      = (st == S_FLUSH);
  assign state      = st;

endmodule

// File: doc/vec_ctrl_unit.md
# vec_ctrl_unit

Parametrised, registered successor to the scalar decode controller. It decodes the 6-bit opcode into the pipeline control word and registers it into the ID/EX boundary. It sequences multi-beat vector ops across `LANES` lanes and owns the BEQ resolve/flush state machine, with a configurable flush depth. It sits between instruction fetch and the execute datapath, and back-pressures fetch through `instn_ready`.

## Interface
- `LANES`, 4: lanes per beat; ≥1.
- `VLEN_MAX`, 16: maximum element count; `VL_W = $clog2(VLEN_MAX+1)`; `BEAT_W = max(1, $clog2(ceil(VLEN_MAX/LANES)))`.
- `FLUSH_CYCLES`, 2: flush pulses after a taken BEQ; 0 allowed.
- `OP_RTYPE` 6'h00, `OP_LW` 6'h23, `OP_SW` 6'h2B, `OP_LW_R` 6'h30, `OP_SW_R` 6'h38, `OP_BEQ` 6'h04, `OP_ADDI` 6'h08, `OP_SET` 6'h0F: opcode encodings.
- `clk` in 1: the single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `instn_valid` in 1: `instn` is valid.
- `instn` in 32: instruction; opcode is `[31:26]`.
- `vlen` in VL_W: element count, sampled on accept.
- `instn_ready` out 1: accept enable. An instruction is accepted when valid && ready at the edge.
- `branch_resolved` in 1: EX has resolved the outstanding BEQ.
- `branch_taken` in 1: BEQ outcome (PCSrc); qualified by `branch_resolved`.
- `ctrl_valid` out 1: the control word below is live this cycle.
- `opcode` out 6, `RegDst` out 1, `ALUOp` out 2, `ALUSrc` out 1, `branch` out 1, `MemWrite` out 1, `RegWrite` out 1, `MemtoReg` out 1: registered control word.
- `beat_idx` out BEAT_W: current beat of a vector op.
- `lane_mask` out LANES: active lanes this beat.
- `beq_enable` out 1: high while a BEQ awaits resolution.
- `flush` out 1: squash the younger fetched instruction.
- `state` out 2: current FSM state.

## Operation
- **Decode table** (RegDst/ALUOp/ALUSrc/branch/MemWrite/RegWrite/MemtoReg):
  - RTYPE 1/10/0/0/0/1/0
  - LW 0/10/1/0/0/1/1
  - SW 0/00/1/0/1/0/0
  - LW_R 1/10/0/0/0/1/1
  - SW_R 1/10/0/0/1/0/0
  - BEQ 0/01/0/1/0/0/0
  - ADDI and SET 0/00/1/0/0/1/0
  - Any other opcode: all zero, but `ctrl_valid`=1.
- When `ctrl_valid`=0, every control output, `opcode`, `beat_idx` and `lane_mask` are forced to 0.
- **Vector ops** are RTYPE, LW_R and SW_R.
  - `vlen` is clamped to VLEN_MAX. beats = ceil(vlen/LANES), minimum 1.
  - In beat k, lane_mask bit i is set when i < min(LANES, vlen − k·LANES). `vlen`=0 gives one beat with mask 0; controls are still as decoded.
- **Scalar ops**: one beat, `lane_mask`=1, `beat_idx`=0.
- **FSM states**: NORMAL=2'b00, BEQ_WAIT=2'b01, FLUSH=2'b10, VEC=2'b11.
- `instn_ready` = (state==NORMAL). It is a Moore output.
- **NORMAL**, on accept: register the decode, `ctrl_valid`=1 next cycle.
  - BEQ → BEQ_WAIT.
  - Vector op with beats>1 → VEC, with the remaining-beat counter set to beats−1.
  - Otherwise stay in NORMAL.
  - With no accept: `ctrl_valid`=0 next cycle.
- **VEC**: each cycle, re-issue the held control word with `beat_idx`+1 and the next mask. After the last beat → NORMAL.
- **BEQ_WAIT**: `beq_enable`=1. The BEQ control word is valid for its first cycle only, then `ctrl_valid`=0.
  - On `branch_resolved`: if taken → FLUSH (or NORMAL when FLUSH_CYCLES=0); if not taken → NORMAL.
  - Without `branch_resolved`, stay indefinitely.
- **FLUSH**: `flush`=1 for exactly FLUSH_CYCLES cycles, then NORMAL. `ctrl_valid`=0 throughout.
- **Illegal state encoding**: not reachable, since all four encodings are used. The FSM still defaults to NORMAL.

## Timing
- **Reset values**: `rst` asserted at any time, including mid-vector or mid-flush, gives on the next settle:
  - `state`=NORMAL, `instn_ready`=1
  - `ctrl_valid`=0, all control outputs 0, `beat_idx`=0, `lane_mask`=0
  - `flush`=0, `beq_enable`=0, counters 0
- **Latency**: control word appears 1 cycle after the accepting edge.
- **Vector throughput**: an op of N beats occupies N consecutive `ctrl_valid` cycles. The next accept happens at the edge that ends the last beat (`instn_ready` rises in that cycle).
- **BEQ timing**:
  - `beq_enable` rises the cycle after the BEQ is accepted.
  - `branch_resolved` is sampled from that cycle on.
  - `flush` begins the cycle after a taken resolve.
  - The next accept is possible 1 cycle after resolve when not taken, or 1+FLUSH_CYCLES cycles after resolve when taken.
- `branch_resolved`/`branch_taken` are ignored outside BEQ_WAIT.
- `vlen` and `instn` changes after accept have no effect on an op in progress.

## Test plan
- **Reset then RTYPE**: `rst` pulse, then RTYPE with vlen=4 and LANES=4 → one cycle later, `ctrl_valid`=1, RegDst=1, ALUOp=10, RegWrite=1, lane_mask=4'b1111; `instn_ready` stays 1.
- **Multi-beat LW_R**: LW_R with vlen=10 → 3 beats; beat_idx 0/1/2; masks 1111/1111/0011; `instn_ready`=0 for 2 cycles; MemtoReg=1 on all 3 beats.
- **Taken BEQ**: BEQ, `branch_resolved`=1 with taken=1 two cycles later → `flush`=1 for exactly 2 cycles, then `instn_ready`=1. Repeat with FLUSH_CYCLES=0 → NORMAL directly.
- **Not-taken BEQ and unqualified taken**: BEQ resolved with taken=0 → no `flush`, NORMAL next cycle. Holding `branch_taken`=1 with `branch_resolved`=0 for 5 cycles → FSM stays in BEQ_WAIT.
- **Edge-case decodes**: SW with vlen=20 and VLEN_MAX=16 → one beat, mask 0001, MemWrite=1. RTYPE with vlen=0 → one beat, mask 0. Opcode 6'h3F → `ctrl_valid`=1 with all controls 0.
- **Async reset mid-op**: assert `rst` asynchronously during beat 1 of a vlen=16 op → outputs drop to reset values without waiting for a clock edge, and no further beats are issued.
